sub_bytes_seq: RTL and testbench



---
 rtl/sub_bytes_seq_if.sv | 32 +++
 rtl/sub_bytes_seq.sv | 102 ++++++++++
 tb/tb_sub_bytes_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sub_bytes_seq_if.sv
// Handshake bundle between the state producer, the iterative SubBytes
// stage and the downstream shiftRows consumer.
// State layout: first index = column, second index = row.
interface sub_bytes_seq_if;
    logic                     in_valid;
    logic                     in_ready;
    logic [0:3][0:3][7:0]     state_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [0:3][0:3][7:0]     state_out;
    logic                     busy;

    modport slave (
        input  in_valid,
        output in_ready,
        input  state_in,
        output out_valid,
        input  out_ready,
        output state_out,
        output busy
    );

    modport master (
        output in_valid,
        input  in_ready,
        output state_in,
        input  out_valid,
        output out_ready,
        input  state_out,
        input  busy
    );
endinterface

// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes: substitutes LANES bytes per cycle through shared
// forward S-box lookups, then holds the finished state for shiftRows.
// Bytes are walked column-major (k = col*4 + row). This is the same order as
// the packed state layout, so the state register is kept as a flat byte array.
module sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic            clk,
    input  logic            rst,
    sub_bytes_seq_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    state_e           state_q, state_d;
    logic [3:0]       k_q, k_d;
    logic [0:15][7:0] data_q, data_d;
    logic             last_grp;

    // Group that finishes the state: k wraps to 0 once it has been substituted.
    assign last_grp = (k_q == 4'(16 - LANES));

    // The output is the state register itself. Downstream must qualify it with out_valid.
    assign bus.state_out = data_q;

    // State, byte index and data registers; reset clears everything so no
    // partial result survives an abort
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            data_q  <= data_d;
        end
    end

    // Next FSM state: accept in IDLE, run ITER substitution cycles, hold until consumed
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = SUB;
            SUB:     if (last_grp)      state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Datapath next values: capture on accept, substitute one byte group per SUB cycle
    always_comb begin
        k_d    = k_q;
        data_d = data_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d = bus.state_in;
                    k_d    = '0;
                end
            end
            SUB: begin
                for (int l = 0; l < LANES; l++) begin
                    data_d[k_q + 4'(l)] = sbox(data_q[k_q + 4'(l)]);
                end
                k_d = last_grp ? 4'd0 : k_q + 4'(LANES);
            end
            default: ;
        endcase
    end

    // Handshake outputs decoded purely from the state register
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq: FIPS-197 vector, boundary bytes,
// back-pressure, mid-operation reset and a LANES sweep.
module tb_sub_bytes_seq;

    typedef logic [0:3][0:3][7:0] st_t;
    typedef struct {
        st_t din;
        st_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sub_bytes_seq_if b4 ();
    sub_bytes_seq_if b1 ();
    sub_bytes_seq_if b2 ();
    sub_bytes_seq_if b16 ();

    sub_bytes_seq #(.LANES(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));
    sub_bytes_seq #(.LANES(1))  dut1  (.clk(clk), .rst(rst), .bus(b1));
    sub_bytes_seq #(.LANES(2))  dut2  (.clk(clk), .rst(rst), .bus(b2));
    sub_bytes_seq #(.LANES(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

    int n_cmp = 0;
    int n_bad = 0;

    localparam st_t FIPS_IN  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
    localparam st_t FIPS_OUT = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Present one state to the LANES=4 instance; returns just after the accept edge
    task automatic start4(input st_t din);
        @(negedge clk);
        chk("accept_ready", 128'(b4.in_ready), 128'd1);
        b4.state_in = din;
        b4.in_valid = 1'b1;
        @(posedge clk);
        #1 b4.in_valid = 1'b0;
    endtask

    // Count edges after accept until out_valid; bounded
    task automatic wait4(output int lat);
        int c;
        c   = 0;
        lat = -1;
        while (lat < 0 && c < 40) begin
            @(posedge clk);
            #1;
            c++;
            if (b4.out_valid) lat = c;
        end
        chk("done_seen", 128'(b4.out_valid), 128'd1);
    endtask

    task automatic ack4;
        b4.out_ready = 1'b1;
        @(posedge clk);
        #1 b4.out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[4];
        st_t  tmp;
        int   lat, lat1, lat2, lat16;

        vecs[0].din = FIPS_IN;
        vecs[0].exp = FIPS_OUT;
        vecs[1].din = '0;
        vecs[1].exp = {16{8'h63}};
        vecs[2].din = {16{8'hff}};
        vecs[2].exp = {16{8'h16}};
        tmp = '0;
        tmp[1][2] = 8'h53;
        vecs[3].din = tmp;
        tmp = {16{8'h63}};
        tmp[1][2] = 8'hed;
        vecs[3].exp = tmp;

        rst = 1'b0;
        b4.in_valid  = 1'b0; b4.out_ready  = 1'b0; b4.state_in  = '0;
        b1.in_valid  = 1'b0; b1.out_ready  = 1'b0; b1.state_in  = '0;
        b2.in_valid  = 1'b0; b2.out_ready  = 1'b0; b2.state_in  = '0;
        b16.in_valid = 1'b0; b16.out_ready = 1'b0; b16.state_in = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 128'(b4.out_valid), 128'd0);
        chk("rst_busy",      128'(b4.busy),      128'd0);
        chk("rst_state_out", b4.state_out,       128'd0);
        chk("rst_in_ready",  128'(b4.in_ready),  128'd1);

        // Table-driven vectors on LANES=4
        for (int i = 0; i < 4; i++) begin
            start4(vecs[i].din);
            wait4(lat);
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
            chk($sformatf("vec%0d_state", i), b4.state_out, vecs[i].exp);
            chk($sformatf("vec%0d_busy", i), 128'(b4.busy), 128'd1);
            ack4();
        end

        // Back-pressure with a competing in_valid
        start4(FIPS_IN);
        wait4(lat);
        b4.state_in = {16{8'hff}};
        b4.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_state", c), b4.state_out, FIPS_OUT);
            chk($sformatf("bp%0d_in_ready", c), 128'(b4.in_ready), 128'd0);
            chk($sformatf("bp%0d_out_valid", c), 128'(b4.out_valid), 128'd1);
        end
        b4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b4.out_ready = 1'b0;
        chk("bp_after_in_ready",  128'(b4.in_ready),  128'd1);
        chk("bp_after_out_valid", 128'(b4.out_valid), 128'd0);
        chk("bp_after_state",     b4.state_out,       FIPS_OUT);
        b4.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_no_capture_busy", 128'(b4.busy), 128'd0);

        // Reset two cycles into SUB
        start4(FIPS_IN);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_busy_before", 128'(b4.busy), 128'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 128'(b4.out_valid), 128'd0);
        chk("mid_rst_state",     b4.state_out,       128'd0);
        chk("mid_rst_busy",      128'(b4.busy),      128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        start4(FIPS_IN);
        wait4(lat);
        chk("post_rst_latency", 128'(lat), 128'd4);
        chk("post_rst_state",   b4.state_out, FIPS_OUT);
        ack4();

        // LANES sweep: 1, 2, 16 in lockstep
        @(negedge clk);
        b1.state_in = FIPS_IN;  b1.in_valid = 1'b1;
        b2.state_in = FIPS_IN;  b2.in_valid = 1'b1;
        b16.state_in = FIPS_IN; b16.in_valid = 1'b1;
        @(posedge clk);
        #1;
        b1.in_valid = 1'b0; b2.in_valid = 1'b0; b16.in_valid = 1'b0;
        lat1 = -1; lat2 = -1; lat16 = -1;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
            if (lat1  < 0 && b1.out_valid)  lat1  = c;
            if (lat2  < 0 && b2.out_valid)  lat2  = c;
            if (lat16 < 0 && b16.out_valid) lat16 = c;
        end
        chk("l1_latency",  128'(lat1),  128'd16);
        chk("l2_latency",  128'(lat2),  128'd8);
        chk("l16_latency", 128'(lat16), 128'd1);
        chk("l1_state",  b1.state_out,  FIPS_OUT);
        chk("l2_state",  b2.state_out,  FIPS_OUT);
        chk("l16_state", b16.state_out, FIPS_OUT);
        b1.out_ready = 1'b1; b2.out_ready = 1'b1; b16.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b1.out_ready = 1'b0; b2.out_ready = 1'b0; b16.out_ready = 1'b0;
        chk("sweep_ready", {125'd0, b1.in_ready, b2.in_ready, b16.in_ready}, 128'd7);
        chk("sweep_idle",  {125'd0, b1.busy, b2.busy, b16.busy}, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
